// File: rtl/proc_pkg.sv
// Shared types for the 4-bit processor controller: opcodes, FSM states, widths.
// Decoded control bundle carried from instr_decoder to control_unit.
package proc_pkg;

  localparam int INSTR_W = 12;
  localparam int DATA_W  = 4;
  localparam int RF_AW   = 3;
  localparam int DM_AW   = 4;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b101,
    OP_SUB   = 3'b110
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB
  } state_t;

  typedef struct packed {
    logic             writes_rf;
    logic             writes_dm;
    logic             wb_sel;
    logic             alu_op;
    logic             illegal;
    logic [RF_AW-1:0] ra1;
    logic [RF_AW-1:0] ra2;
    logic [RF_AW-1:0] wa;
    logic [DM_AW-1:0] dm_addr;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational IR -> control field decode, zero latency, no flow control.
// Fields are ungated here; control_unit qualifies them by FSM state.
module instr_decoder
  import proc_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output ctrl_t              ctrl
);

  opcode_t op;

  assign op = opcode_t'(ir[11:9]);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_LOAD: begin
        ctrl.writes_rf = 1'b1;
        ctrl.dm_addr   = ir[7:4];
        ctrl.wa        = ir[2:0];
      end
      OP_STORE: begin
        ctrl.writes_dm = 1'b1;
        ctrl.dm_addr   = ir[7:4];
        ctrl.ra2       = ir[2:0];
      end
      OP_ADD, OP_SUB: begin
        ctrl.writes_rf = 1'b1;
        ctrl.wb_sel    = 1'b1;
        ctrl.alu_op    = (op == OP_SUB);
        ctrl.ra1       = ir[5:3];
        ctrl.ra2       = ir[2:0];
        ctrl.wa        = ir[8:6];
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/WB, one instruction per 4 cycles.
// Started by run (back to back) or step (single instruction from IDLE).
module control_unit
  import proc_pkg::*;
#(
  parameter int IM_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        step,
  input  logic [INSTR_W-1:0]          im_data,
  output logic [$clog2(IM_DEPTH)-1:0] im_addr,
  output logic [RF_AW-1:0]            rf_ra1,
  output logic [RF_AW-1:0]            rf_ra2,
  output logic [RF_AW-1:0]            rf_wa,
  output logic                        rf_we,
  output logic                        wb_sel,
  output logic [DM_AW-1:0]            dm_addr,
  output logic                        dm_we,
  output logic                        alu_op,
  output logic                        busy,
  output logic                        illegal
);

  localparam int PC_W = $clog2(IM_DEPTH);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  ctrl_t              ctrl;
  logic               decoded;

  instr_decoder u_dec (
    .ir   (ir),
    .ctrl (ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        IDLE:    if (run || step) state <= FETCH;
        FETCH: begin
          ir    <= im_data;
          state <= DECODE;
        end
        DECODE:  state <= EXEC;
        EXEC:    state <= WB;
        WB: begin
          pc    <= pc + 1'b1;
          state <= run ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign decoded = (state == DECODE) || (state == EXEC) || (state == WB);
  assign im_addr = pc;
  assign busy    = (state != IDLE);

  // Strobes are masked by reset so an abandoned instruction never commits.
  always_comb begin
    rf_ra1  = '0;
    rf_ra2  = '0;
    rf_wa   = '0;
    dm_addr = '0;
    wb_sel  = 1'b0;
    alu_op  = 1'b0;
    if (decoded) begin
      rf_ra1  = ctrl.ra1;
      rf_ra2  = ctrl.ra2;
      rf_wa   = ctrl.wa;
      dm_addr = ctrl.dm_addr;
      wb_sel  = ctrl.wb_sel;
      alu_op  = ctrl.alu_op;
    end
    rf_we   = (state == WB)   && ctrl.writes_rf && !reset;
    dm_we   = (state == EXEC) && ctrl.writes_dm && !reset;
    illegal = (state == WB)   && ctrl.illegal   && !reset;
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: stimulus queues expected
// per-instruction behaviour, a negedge monitor assembles and compares it.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [11:0] im_data;
  logic [3:0]  im_addr;
  logic [2:0]  rf_ra1, rf_ra2, rf_wa;
  logic        rf_we, wb_sel, dm_we, alu_op, busy, illegal;
  logic [3:0]  dm_addr;

  logic [11:0] im [16];
  assign im_data = im[im_addr];

  always #5 clk = ~clk;

  control_unit #(.IM_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .im_data(im_data), .im_addr(im_addr),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we),
    .wb_sel(wb_sel), .dm_addr(dm_addr), .dm_we(dm_we), .alu_op(alu_op),
    .busy(busy), .illegal(illegal)
  );

  typedef struct packed {
    logic [3:0] pc;
    logic [2:0] ra1, ra2, wa;
    logic [3:0] dm_addr;
    logic       wb_sel, alu_op;
    logic [3:0] rfwe_m, dmwe_m, ill_m;  // bit index = FETCH,DECODE,EXEC,WB
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] pc_m = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Instruction semantics written straight from the opcode table.
  function automatic exp_t model(input logic [3:0] pc, input logic [11:0] ins);
    exp_t e;
    logic [2:0] op;
    e = '0;
    e.pc = pc;
    op = ins[11:9];
    if (op == 3'b000) begin
      e.dm_addr = ins[7:4]; e.wa = ins[2:0]; e.rfwe_m = 4'b1000;
    end else if (op == 3'b001) begin
      e.dm_addr = ins[7:4]; e.ra2 = ins[2:0]; e.dmwe_m = 4'b0100;
    end else if (op == 3'b101 || op == 3'b110) begin
      e.ra1 = ins[5:3]; e.ra2 = ins[2:0]; e.wa = ins[8:6];
      e.wb_sel = 1'b1; e.alu_op = (op == 3'b110); e.rfwe_m = 4'b1000;
    end else begin
      e.ill_m = 4'b1000;
    end
    return e;
  endfunction

  function automatic logic [14:0] exp_vec(input exp_t e);
    return {e.ra1, e.ra2, e.wa, e.dm_addr, e.wb_sel, e.alu_op};
  endfunction

  // Monitor: busy phases map to FETCH..WB; a transaction closes at WB.
  int          phase = 0;
  logic [3:0]  obs_pc;
  logic [14:0] obs_vec [4];
  logic [3:0]  obs_rfwe, obs_dmwe, obs_ill;

  always @(negedge clk) begin
    if (reset || !busy) begin
      phase = 0;
    end else begin
      if (phase == 0) begin
        obs_pc = im_addr;
        obs_rfwe = '0; obs_dmwe = '0; obs_ill = '0;
      end
      obs_vec[phase]   = {rf_ra1, rf_ra2, rf_wa, dm_addr, wb_sel, alu_op};
      obs_rfwe[phase]  = rf_we;
      obs_dmwe[phase]  = dm_we;
      obs_ill[phase]   = illegal;
      if (phase == 3) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr", {28'd0, obs_pc}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fetch_addr",  {28'd0, obs_pc}, {28'd0, e.pc});
          chk("fetch_zero",  {17'd0, obs_vec[0]}, 32'd0);
          chk("decode_ctl",  {17'd0, obs_vec[1]}, {17'd0, exp_vec(e)});
          chk("exec_ctl",    {17'd0, obs_vec[2]}, {17'd0, exp_vec(e)});
          chk("wb_ctl",      {17'd0, obs_vec[3]}, {17'd0, exp_vec(e)});
          chk("rf_we_mask",  {28'd0, obs_rfwe}, {28'd0, e.rfwe_m});
          chk("dm_we_mask",  {28'd0, obs_dmwe}, {28'd0, e.dmwe_m});
          chk("illegal_mask",{28'd0, obs_ill},  {28'd0, e.ill_m});
        end
      end
      phase = (phase + 1) % 4;
    end
  end

  function automatic logic [22:0] all_outs();
    return {im_addr, rf_ra1, rf_ra2, rf_wa, rf_we, wb_sel, dm_addr, dm_we, alu_op, busy, illegal};
  endfunction

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
    end
    if (!done) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_step(input bool_extra);
    exp_q.push_back(model(pc_m, im[pc_m]));
    pc_m = pc_m + 4'd1;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    if (bool_extra) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
    end
    wait_idle("step");
  endtask

  task automatic run_n(input int n, input bit with_step);
    for (int k = 0; k < n; k++) exp_q.push_back(model(pc_m + 4'(k), im[pc_m + 4'(k)]));
    pc_m = pc_m + 4'(n);
    @(negedge clk); run = 1'b1; step = with_step;
    @(posedge clk); #1 step = 1'b0;
    repeat (4 * n - 3) @(posedge clk);
    #1 run = 1'b0;
    wait_idle("run");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) im[i] = 12'h000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", {9'd0, all_outs()}, 32'd0);
    end

    // LOAD DM[2] -> R5 by step, with a stray step pulse mid-instruction
    im[0] = 12'h025;
    do_step(1'b1);
    repeat (3) @(negedge clk);
    chk("step_once_busy", {31'd0, busy}, 32'd0);
    chk("step_pc", {28'd0, im_addr}, 32'd1);

    // ADD R3 = R1 + R2 then a SUB back to back
    im[1] = 12'b101_011_001_010;
    im[2] = 12'b110_111_100_001;
    run_n(2, 1'b0);
    im[3] = 12'h274;
    run_n(1, 1'b0);
    im[4] = 12'hE5A;
    do_step(1'b0);
    chk("illegal_pc_adv", {28'd0, im_addr}, 32'd5);

    // 16 back-to-back instructions wrap the PC to its start
    for (int i = 0; i < 16; i++) im[i] = 12'($urandom_range(0, 4095));
    run_n(16, 1'b1);
    chk("wrap_pc", {28'd0, im_addr}, {28'd0, pc_m});

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) im[i] = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 2) == 0) do_step(1'($urandom_range(0, 1)));
      else run_n(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
      chk("rand_pc", {28'd0, im_addr}, {28'd0, pc_m});
    end

    // Reset during EXEC of a STORE abandons it without a DM write
    im[pc_m] = 12'h2A3;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_exec_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_exec_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    pc_m = 4'd0;
    @(negedge clk);
    chk("post_rst_outputs", {9'd0, all_outs()}, 32'd0);
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
